// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
  endfunction

  // Out-of-range digits saturate at 9 so the count is always valid BCD.
  function automatic logic [7:0] bcd_sanitise(input logic [7:0] v);
    return {bcd_clamp(v[7:4]), bcd_clamp(v[3:0])};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, BCD_DIGIT_MAX};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags a step on the last count.
module tick_gen #(
  parameter int unsigned DIV = 50000000
) (
  input  logic ck,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign step = en && (cnt == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// BCD countdown timer with start/pause edge controls.
// Optional auto-reload at terminal count: define TIMER_AUTO_RELOAD_EN.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] preset,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       wrap,
  output state_t     dbg_state
);

`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  state_t     state, state_nxt;
  logic       start_prev, pause_prev, armed;
  logic       start_edge, pause_edge;
  logic       step, last_step, run_en;
  logic [7:0] preset_san, q_nxt, reload_val;

  assign preset_san = bcd_sanitise(preset);
  assign start_edge = armed & start & ~start_prev;
  assign pause_edge = armed & pause & ~pause_prev;
  assign run_en     = (state == RUN);
  assign last_step  = run_en & step & (q == 8'h01);

  // armed stays low for the first clock after reset so a level held high
  // through release is captured into prev instead of reading as an edge.
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      start_prev <= start;
      pause_prev <= pause;
      armed      <= 1'b1;
    end
  end

  tick_gen #(.DIV(DIV)) u_tick (
    .ck   (ck),
    .rs   (rs),
    .en   (run_en),
    .clr  (start_edge),
    .step (step)
  );

  always_ff @(posedge ck or posedge rs) begin
    if (rs) state <= IDLE;
    else    state <= state_nxt;
  end

  // start outranks everything; a terminal step outranks a same-cycle pause.
  always_comb begin
    state_nxt = state;
    if (start_edge) begin
      state_nxt = (preset_san == 8'h00) ? DONE : RUN;
    end else begin
      case (state)
        RUN: begin
          if (last_step && !AUTO_RELOAD) state_nxt = DONE;
          else if (pause_edge)           state_nxt = PAUSE;
        end
        PAUSE:   if (pause_edge) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN) || (state == PAUSE);
    done = (state == DONE);
  end

  always_comb begin
    q_nxt = q;
    if (start_edge)          q_nxt = preset_san;
    else if (run_en && step) q_nxt = (q == 8'h01) ? reload_val : bcd_dec(q);
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) q <= 8'h00;
    else    q <= q_nxt;
  end

`ifdef TIMER_AUTO_RELOAD_EN
  logic [7:0] reload_r;
  logic       wrap_r;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      reload_r <= 8'h00;
      wrap_r   <= 1'b0;
    end else begin
      if (start_edge) reload_r <= preset_san;
      wrap_r <= last_step & ~start_edge;
    end
  end

  assign reload_val = reload_r;
  assign wrap       = wrap_r;
`else
  assign reload_val = 8'h00;
  assign wrap       = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl (DIV = 4) against a decimal reference model.
module tb_timer_ctrl;

  localparam int DIV = 4;
  localparam int W   = 13;

  logic       ck = 1'b0;
  logic       rs = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [7:0] q;
  logic       busy, done, wrap;
  logic [1:0] dbg_state;

  timer_ctrl #(.DIV(DIV)) dut (
    .ck        (ck),
    .rs        (rs),
    .start     (start),
    .pause     (pause),
    .preset    (preset),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model: mode uses 0 idle, 1 run, 2 pause, 3 done; value is decimal
  int m_mode   = 0;
  int m_val    = 0;
  int m_reload = 0;
  int m_ticks  = 0;
  bit m_ps = 0, m_pp = 0, m_armed = 0, m_wrap = 0;

  function automatic int san(input logic [7:0] p);
    int t, o;
    t = int'(p[7:4]);
    o = int'(p[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [W-1:0] exp_word();
    logic [7:0] qb;
    qb = 8'(((m_val / 10) << 4) | (m_val % 10));
    return {2'(m_mode), qb, (m_mode == 1 || m_mode == 2), (m_mode == 3), m_wrap};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_val = 0; m_ticks = 0; m_reload = 0;
    m_ps = 0; m_pp = 0; m_armed = 0; m_wrap = 0;
  endtask

  task automatic model_clock(input bit r, input bit s, input bit p, input logic [7:0] pre);
    bit se, pe;
    if (r) begin
      model_reset();
    end else begin
      se = m_armed && s && !m_ps;
      pe = m_armed && p && !m_pp;
      m_ps = s;
      m_pp = p;
      m_armed = 1;
      m_wrap = 0;
      if (se) begin
        m_reload = san(pre);
        m_val    = m_reload;
        m_ticks  = 0;
        m_mode   = (m_val == 0) ? 3 : 1;
      end else if (m_mode == 1) begin
        m_ticks++;
        if (m_ticks == DIV) begin
          m_ticks = 0;
          if (m_val == 1) begin
`ifdef TIMER_AUTO_RELOAD_EN
            m_val  = m_reload;
            m_wrap = 1;
`else
            m_val  = 0;
            m_mode = 3;
`endif
          end else begin
            m_val--;
          end
        end
        if (pe && m_mode == 1) m_mode = 2;
      end else if (m_mode == 2 && pe) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h required=%h", name, $time, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input bit r, input bit s, input bit p, input logic [7:0] pre);
    @(negedge ck);
    rs = r; start = s; pause = p; preset = pre;
    model_clock(r, s, p, pre);
    exp_q.push_back(exp_word());
  endtask

  task automatic hold(input int n, input bit s, input bit p, input logic [7:0] pre);
    for (int i = 0; i < n; i++) cyc(1'b0, s, p, pre);
  endtask

  task automatic rst_now();
    @(negedge ck);
    rs = 1'b1;
    model_reset();
    #1;
    check("async_reset", {dbg_state, q, busy, done, wrap}, exp_word());
  endtask

  // monitor
  always @(posedge ck) begin
    #1;
    if (exp_q.size() != 0) check("outputs", {dbg_state, q, busy, done, wrap}, exp_q.pop_front());
  end

  logic [7:0] presets[10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h12, 8'hAF, 8'hA3, 8'h9B, 8'h07};

  initial begin
    bit s, p;
    int r_cnt;
    logic [7:0] pre;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    hold(2, 0, 0, 8'h12);

    // full countdown from 12
    cyc(0, 1, 0, 8'h12);
    hold(12 * DIV + 4, 0, 0, 8'h12);

    // pause / resume from 05
    cyc(0, 1, 0, 8'h05);
    hold(5, 0, 0, 8'h05);
    cyc(0, 0, 1, 8'h05);
    hold(20, 0, 0, 8'h05);
    cyc(0, 0, 1, 8'h05);
    hold(12, 0, 0, 8'h05);

    // sanitising, ignored preset changes, zero preset
    cyc(0, 1, 0, 8'hAF);
    @(posedge ck); #2;
    check("sanitise_af", {5'd0, q}, {5'd0, 8'h99});
    hold(6, 0, 0, 8'hA3);
    cyc(0, 1, 0, 8'hA3);
    hold(3, 0, 0, 8'hA3);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    @(posedge ck); #2;
    check("zero_preset_done", {11'd0, busy, done}, 13'b01);
    hold(4, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    hold(2, 0, 0, 8'h00);

    // start and pause rising together while running
    cyc(0, 1, 0, 8'h08);
    hold(6, 0, 0, 8'h08);
    cyc(0, 1, 1, 8'h08);
    hold(6, 0, 0, 8'h08);

    // reset mid-run with start held through release
    cyc(0, 1, 0, 8'h09);
    hold(2 * DIV + 1, 0, 0, 8'h09);
    rst_now();
    cyc(1, 1, 0, 8'h09);
    cyc(1, 1, 0, 8'h09);
    hold(10, 1, 0, 8'h09);
    hold(3, 0, 0, 8'h09);

`ifdef TIMER_AUTO_RELOAD_EN
    cyc(0, 1, 0, 8'h02);
    hold(30, 0, 0, 8'h02);
`endif

    // randomized phase
    s = 0; p = 0; r_cnt = 0; pre = 8'h05;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) s = ~s;
      if ($urandom_range(0, 99) < 6) p = ~p;
      if ($urandom_range(0, 99) < 8)
        pre = ($urandom_range(0, 9) == 0) ? 8'($urandom) : presets[$urandom_range(0, 9)];
      if (r_cnt == 0 && $urandom_range(0, 399) == 0) r_cnt = $urandom_range(1, 3);
      cyc(r_cnt > 0, s, p, pre);
      if (r_cnt > 0) r_cnt--;
    end
    hold(4, 0, 0, pre);

    repeat (3) @(posedge ck);
    #3;
    check("queue_drained", 13'(exp_q.size()), 13'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have one parameter DIV, default 50000000, meaning clock cycles per count step (legal range 2 and above).
REQ-002 The block SHALL have port ck, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rs, input, 1 bit, the asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a level input that is rising-edge detected internally to load and run.
REQ-005 The block SHALL have port pause, input, 1 bit, a level input that is rising-edge detected internally to toggle run/hold.
REQ-006 The block SHALL have port preset, input, 8 bits, the BCD start value (tens in [7:4], ones in [3:0]).
REQ-007 The block SHALL have port q, output, 8 bits, the current BCD count, suitable for direct per-digit 7-segment encoding.
REQ-008 The block SHALL have port busy, output, 1 bit, high in RUN or PAUSE.
REQ-009 The block SHALL have port done, output, 1 bit, high while in DONE.
REQ-010 The block SHALL have port wrap, output, 1 bit, a one-cycle pulse on auto-reload.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-012 Edge detect SHALL work as follows: prev registers hold last-cycle start/pause; edge = input high and prev low; the action SHALL commit on that same clock edge, so q shows the new value one cycle after start first rises.
REQ-013 Preset SHALL be sanitised: any digit above 9 SHALL be loaded as 9 (e.g. 8'hA3 loads as 8'h93).
REQ-014 A start edge in any state SHALL load the sanitised preset into q, clear the prescaler and go to RUN; if the sanitised preset is 8'h00, it SHALL go to DONE instead.
REQ-015 In RUN, the prescaler SHALL count 0..DIV-1; at DIV-1 it SHALL wrap to 0 and issue one step, giving exactly one step every DIV cycles.
REQ-016 A step SHALL work as follows: ones 1..9 decrement; ones 0 becomes 9 and tens decrements; the result SHALL always be valid BCD.
REQ-017 A step taken at q = 8'h01 SHALL set q to 8'h00 and go to DONE (unless reload is configured, see Configuration).
REQ-018 A pause edge in RUN SHALL go to PAUSE with q and the prescaler frozen.
REQ-019 A pause edge in PAUSE SHALL return to RUN and resume from the frozen prescaler value, with no lost or extra cycles.
REQ-020 A pause edge in IDLE or DONE SHALL be ignored.
REQ-021 If start and pause edges occur in the same cycle, start SHALL win and pause SHALL be ignored.
REQ-022 Preset changes SHALL be ignored except at a start edge.
REQ-023 busy SHALL be a registered-state decode with no combinational path from inputs.
REQ-024 done SHALL be a registered-state decode with no combinational path from inputs.

Reset
REQ-025 rs high SHALL immediately (asynchronously) force: state IDLE, q = 8'h00, prescaler = 0, prev registers = 0, busy = 0, done = 0, wrap = 0.
REQ-026 rs asserted mid-RUN or mid-PAUSE SHALL abandon the count.
REQ-027 After rs releases, the block SHALL remain in IDLE until a start edge.
REQ-028 An input held high through reset release SHALL NOT produce an edge.

Configuration
REQ-029 Macro TIMER_AUTO_RELOAD_EN defined: a step at q = 8'h01 SHALL reload the sanitised preset, stay in RUN and pulse wrap for one cycle; DONE SHALL then be reachable only via a start edge with a zero preset.
REQ-030 Macro TIMER_AUTO_RELOAD_EN undefined: wrap SHALL be tied to 0 and behaviour SHALL be as REQ-017.

Structure
REQ-031 Package timer_pkg SHALL hold the state typedef (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and the BCD digit-max constant 4'd9.
REQ-032 The BCD decrement and sanitise SHALL be package functions.
REQ-033 The block SHALL have one sub-module, tick_gen (prescaler with enable, clear and step output), parameterised by DIV.

Verification (DIV = 4)
REQ-034 Scenario: preset 8'h12, start pulse -> q sequence 12,11,10,09,...,01,00 at 4-cycle spacing; done rises with q = 00; busy falls the same cycle.
REQ-035 Scenario: preset 8'h05, start, pause after 6 cycles, hold 20 cycles, pause again -> q frozen at 04 during hold; next step lands exactly 2 cycles after resume.
REQ-036 Scenario: preset 8'hAF -> q loads 8'h99; preset 8'h00 -> direct to DONE with busy never high.
REQ-037 Scenario: start and pause rising together in RUN -> reload to preset, state RUN, no PAUSE.
REQ-038 Scenario: rs pulsed mid-RUN at q = 07 -> q = 00 and IDLE immediately; start held high across release produces no run.
REQ-039 Scenario: with TIMER_AUTO_RELOAD_EN and preset 8'h02 -> q sequence 02,01,02,01..., one wrap pulse per reload, done never high.
